// File: rtl/vip_edge_pkg.sv
// Shared coordinate/counter widths and FSM states for the VIP edge statistics stages.
// Declarations only: no latency, no flow control.
package vip_edge_pkg;
  localparam int VIP_X_W   = 11;
  localparam int VIP_Y_W   = 11;
  localparam int VIP_CNT_W = 22;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    REPORT   = 2'd2
  } vip_state_t;
endpackage

// File: rtl/vip_frame_xy_counter.sv
// vsync edge detect plus x (pixel-in-line) and y (line-in-frame) counters for the current input pixel.
// Coordinates describe the pixel presented this cycle; edges are combinational; no backpressure (stream cannot stall).
module vip_frame_xy_counter
  import vip_edge_pkg::*;
#(
  parameter int X_W = VIP_X_W,
  parameter int Y_W = VIP_Y_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_vsync,
  input  logic           i_href,
  input  logic           i_clken,
  output logic           o_vs_rise,
  output logic           o_vs_fall,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y
);
  logic           r_vsync_d;
  logic           r_href_d;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           w_hs_fall;

  assign o_vs_rise = i_vsync & ~r_vsync_d;
  assign o_vs_fall = ~i_vsync & r_vsync_d;
  assign w_hs_fall = ~i_href & r_href_d;
  assign o_x       = r_x;
  assign o_y       = r_y;

  // vsync history resets high so a frame already in flight at reset release is not seen as a new SOF.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_d <= 1'b1;
      r_href_d  <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      r_vsync_d <= i_vsync;
      r_href_d  <= i_href;
      if (w_hs_fall)
        r_x <= '0;
      else if (i_href && i_clken && !(&r_x))
        r_x <= r_x + X_W'(1);
      if (o_vs_rise)
        r_y <= '0;
      else if (w_hs_fall && !(&r_y))
        r_y <= r_y + Y_W'(1);
    end
  end
endmodule

// File: rtl/vip_edge_bbox_stats.sv
// Per-frame edge-pixel count and bounding box of a binary edge stream, plus 1-cycle re-emitted stream with optional box overlay.
// Stream latency 1 cycle; box_valid 2 cycles after vsync is first sampled low; no backpressure (stream cannot stall).
module vip_edge_bbox_stats
  import vip_edge_pkg::*;
#(
  parameter int X_W          = VIP_X_W,
  parameter int Y_W          = VIP_Y_W,
  parameter int CNT_W        = VIP_CNT_W,
  parameter int MIN_EDGE_CNT = 16,
  parameter bit OVERLAY_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic             per_img_Bit,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic             post_img_Bit,
  output logic             box_valid,
  output logic             box_found,
  output logic [X_W-1:0]   box_xmin,
  output logic [X_W-1:0]   box_xmax,
  output logic [Y_W-1:0]   box_ymin,
  output logic [Y_W-1:0]   box_ymax,
  output logic [CNT_W-1:0] edge_cnt
);
  logic             w_vs_rise, w_vs_fall, w_edge, w_sof, w_hit;
  logic [X_W-1:0]   w_x;
  logic [Y_W-1:0]   w_y;
  vip_state_t       r_state;
  logic [X_W-1:0]   r_acc_xmin, r_acc_xmax, r_box_xmin, r_box_xmax, r_ov_xmin, r_ov_xmax;
  logic [Y_W-1:0]   r_acc_ymin, r_acc_ymax, r_box_ymin, r_box_ymax, r_ov_ymin, r_ov_ymax;
  logic [CNT_W-1:0] r_acc_cnt, r_box_cnt;
  logic             r_box_valid, r_box_found, r_ov_vld;
  logic             r_post_vsync, r_post_href, r_post_clken, r_post_bit;
  logic             w_res_empty, w_res_found, w_src_found;
  logic [X_W-1:0]   w_res_xmin, w_res_xmax, w_src_xmin, w_src_xmax;
  logic [Y_W-1:0]   w_res_ymin, w_res_ymax, w_src_ymin, w_src_ymax;

  vip_frame_xy_counter #(.X_W(X_W), .Y_W(Y_W)) u_xy (
    .clk       (clk),
    .rst       (rst),
    .i_vsync   (per_frame_vsync),
    .i_href    (per_frame_href),
    .i_clken   (per_frame_clken),
    .o_vs_rise (w_vs_rise),
    .o_vs_fall (w_vs_fall),
    .o_x       (w_x),
    .o_y       (w_y)
  );

  assign w_edge = per_frame_href & per_frame_clken & per_img_Bit;
  assign w_sof  = w_vs_rise & (r_state != ACTIVE);

  // An empty frame reports zero coordinates rather than the min/max seed values.
  assign w_res_empty = (r_acc_cnt == '0);
  assign w_res_found = (32'(r_acc_cnt) >= 32'(MIN_EDGE_CNT));
  assign w_res_xmin  = w_res_empty ? '0 : r_acc_xmin;
  assign w_res_xmax  = w_res_empty ? '0 : r_acc_xmax;
  assign w_res_ymin  = w_res_empty ? '0 : r_acc_ymin;
  assign w_res_ymax  = w_res_empty ? '0 : r_acc_ymax;

  // A frame starting in the REPORT cycle must overlay the result being published, not the stale one.
  assign w_src_found = (r_state == REPORT) ? w_res_found : r_box_found;
  assign w_src_xmin  = (r_state == REPORT) ? w_res_xmin  : r_box_xmin;
  assign w_src_xmax  = (r_state == REPORT) ? w_res_xmax  : r_box_xmax;
  assign w_src_ymin  = (r_state == REPORT) ? w_res_ymin  : r_box_ymin;
  assign w_src_ymax  = (r_state == REPORT) ? w_res_ymax  : r_box_ymax;

  always_ff @(posedge clk) begin
    if (rst || w_sof) begin
      r_acc_xmin <= '1;
      r_acc_xmax <= '0;
      r_acc_ymin <= '1;
      r_acc_ymax <= '0;
      r_acc_cnt  <= '0;
    end else if ((r_state == ACTIVE) && w_edge) begin
      if (w_x < r_acc_xmin) r_acc_xmin <= w_x;
      if (w_x > r_acc_xmax) r_acc_xmax <= w_x;
      if (w_y < r_acc_ymin) r_acc_ymin <= w_y;
      if (w_y > r_acc_ymax) r_acc_ymax <= w_y;
      if (!(&r_acc_cnt)) r_acc_cnt <= r_acc_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= WAIT_SOF;
      r_box_valid <= 1'b0;
      r_box_found <= 1'b0;
      r_box_xmin  <= '0;
      r_box_xmax  <= '0;
      r_box_ymin  <= '0;
      r_box_ymax  <= '0;
      r_box_cnt   <= '0;
    end else begin
      r_box_valid <= 1'b0;
      case (r_state)
        WAIT_SOF: if (w_vs_rise) r_state <= ACTIVE;
        ACTIVE:   if (w_vs_fall) r_state <= REPORT;
        REPORT: begin
          r_box_valid <= 1'b1;
          r_box_found <= w_res_found;
          r_box_xmin  <= w_res_xmin;
          r_box_xmax  <= w_res_xmax;
          r_box_ymin  <= w_res_ymin;
          r_box_ymax  <= w_res_ymax;
          r_box_cnt   <= r_acc_cnt;
          r_state     <= w_vs_rise ? ACTIVE : WAIT_SOF;
        end
        default: r_state <= WAIT_SOF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ov_vld  <= 1'b0;
      r_ov_xmin <= '0;
      r_ov_xmax <= '0;
      r_ov_ymin <= '0;
      r_ov_ymax <= '0;
    end else if (w_vs_rise) begin
      r_ov_vld  <= OVERLAY_EN & w_src_found;
      r_ov_xmin <= w_src_xmin;
      r_ov_xmax <= w_src_xmax;
      r_ov_ymin <= w_src_ymin;
      r_ov_ymax <= w_src_ymax;
    end
  end

  assign w_hit = r_ov_vld &
                 ((((w_x == r_ov_xmin) || (w_x == r_ov_xmax)) && (w_y >= r_ov_ymin) && (w_y <= r_ov_ymax)) ||
                  (((w_y == r_ov_ymin) || (w_y == r_ov_ymax)) && (w_x >= r_ov_xmin) && (w_x <= r_ov_xmax)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_post_vsync <= 1'b0;
      r_post_href  <= 1'b0;
      r_post_clken <= 1'b0;
      r_post_bit   <= 1'b0;
    end else begin
      r_post_vsync <= per_frame_vsync;
      r_post_href  <= per_frame_href;
      r_post_clken <= per_frame_clken;
      r_post_bit   <= per_frame_href & (per_img_Bit | (per_frame_clken & w_hit));
    end
  end

  assign post_frame_vsync = r_post_vsync;
  assign post_frame_href  = r_post_href;
  assign post_frame_clken = r_post_clken;
  assign post_img_Bit     = r_post_bit;
  assign box_valid        = r_box_valid;
  assign box_found        = r_box_found;
  assign box_xmin         = r_box_xmin;
  assign box_xmax         = r_box_xmax;
  assign box_ymin         = r_box_ymin;
  assign box_ymax         = r_box_ymax;
  assign edge_cnt         = r_box_cnt;
endmodule

// File: tb/tb_vip_edge_bbox_stats.sv
// Bench for vip_edge_bbox_stats: frame driver with a scoreboard of expected per-frame results,
// plus stream/overlay capture. A second instance with a 4-bit counter exercises saturation.
module tb_vip_edge_bbox_stats;
  logic clk = 1'b0, rst = 1'b1, vs = 1'b0, hs = 1'b0, ce = 1'b0, bi = 1'b0;
  logic o_vs, o_hs, o_ce, o_bit, bv, bf;
  logic [10:0] bxmin, bxmax, bymin, bymax;
  logic [21:0] bcnt;
  logic s_vs, s_hs, s_ce, s_bit, s_bv, s_bf;
  logic [10:0] s_xmin, s_xmax, s_ymin, s_ymax;
  logic [3:0] s_cnt;

  typedef struct {
    bit found;
    int xmin, xmax, ymin, ymax, cnt, vcyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t me;
  int   n_tests = 0, n_fail = 0, cyc = 0, cur_x = 0, cur_y = 0, cur_row = -1, fall_cyc = 0, cs;
  bit   chk_stream = 0, cap_en = 0, cap_en_d = 0, prev_valid = 0;
  logic d_vs, d_hs, d_ce;
  int   d_x, d_y;
  bit   cap [0:47][0:63];

  always #5 clk = ~clk;

  vip_edge_bbox_stats dut (
    .clk(clk), .rst(rst), .per_frame_vsync(vs), .per_frame_href(hs), .per_frame_clken(ce),
    .per_img_Bit(bi), .post_frame_vsync(o_vs), .post_frame_href(o_hs), .post_frame_clken(o_ce),
    .post_img_Bit(o_bit), .box_valid(bv), .box_found(bf), .box_xmin(bxmin), .box_xmax(bxmax),
    .box_ymin(bymin), .box_ymax(bymax), .edge_cnt(bcnt)
  );

  vip_edge_bbox_stats #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .per_frame_vsync(vs), .per_frame_href(hs), .per_frame_clken(ce),
    .per_img_Bit(bi), .post_frame_vsync(s_vs), .post_frame_href(s_hs), .post_frame_clken(s_ce),
    .post_img_Bit(s_bit), .box_valid(s_bv), .box_found(s_bf), .box_xmin(s_xmin), .box_xmax(s_xmax),
    .box_ymin(s_ymin), .box_ymax(s_ymax), .edge_cnt(s_cnt)
  );

  // Monitor: inputs recorded at the edge, outputs sampled 1 time unit later.
  always @(posedge clk) begin
    cyc  = cyc + 1;
    d_vs = vs; d_hs = hs; d_ce = ce; d_x = cur_x; d_y = cur_y;
    #1;
    if (cap_en && !cap_en_d)
      for (int y = 0; y < 48; y++) for (int x = 0; x < 64; x++) cap[y][x] = 1'b0;
    cap_en_d = cap_en;
    if (cap_en && o_hs && o_ce && d_x >= 0 && d_x < 64 && d_y >= 0 && d_y < 48)
      cap[d_y][d_x] = o_bit;
    if (chk_stream) begin
      n_tests++;
      if ({o_vs, o_hs, o_ce, s_vs, s_hs, s_ce} !== {d_vs, d_hs, d_ce, d_vs, d_hs, d_ce} ||
          (!o_hs && o_bit !== 1'b0) || (!s_hs && s_bit !== 1'b0)) begin
        n_fail++;
        $display("FAIL stream_delay cyc=%0d got vs/hs/ce=%b%b%b bit=%b want %b%b%b", cyc, o_vs, o_hs, o_ce, o_bit, d_vs, d_hs, d_ce);
      end
    end
    if (prev_valid) begin
      n_tests++;
      if (bv !== 1'b0) begin n_fail++; $display("FAIL valid_width cyc=%0d box_valid=%b want 0", cyc, bv); end
    end
    prev_valid = (bv === 1'b1);
    if (bv === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_box_valid cyc=%0d got 1 want 0", cyc);
      end else begin
        me = sb_q.pop_front();
        n_tests++;
        if (cyc !== me.vcyc) begin n_fail++; $display("FAIL valid_latency got cyc %0d want %0d", cyc, me.vcyc); end
        n_tests++;
        if ({bxmin, bxmax, bymin, bymax} !== {11'(me.xmin), 11'(me.xmax), 11'(me.ymin), 11'(me.ymax)}) begin
          n_fail++;
          $display("FAIL box_coords got %0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d", bxmin, bxmax, bymin, bymax, me.xmin, me.xmax, me.ymin, me.ymax);
        end
        n_tests++;
        if (bcnt !== 22'(me.cnt) || bf !== me.found) begin
          n_fail++; $display("FAIL cnt_found got cnt=%0d found=%b want cnt=%0d found=%b", bcnt, bf, me.cnt, me.found);
        end
        cs = (me.cnt > 15) ? 15 : me.cnt;
        n_tests++;
        if (s_bv !== 1'b1 || s_cnt !== 4'(cs) || s_bf !== 1'b0 ||
            {s_xmin, s_xmax, s_ymin, s_ymax} !== {11'(me.xmin), 11'(me.xmax), 11'(me.ymin), 11'(me.ymax)}) begin
          n_fail++;
          $display("FAIL sat_dut got valid=%b cnt=%0d found=%b box=%0d,%0d,%0d,%0d want 1,%0d,0,%0d,%0d,%0d,%0d",
                   s_bv, s_cnt, s_bf, s_xmin, s_xmax, s_ymin, s_ymax, cs, me.xmin, me.xmax, me.ymin, me.ymax);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic bit is_edge(input int mode, input int x, input int y);
    case (mode)
      1:       return (x == 3 && y == 2);
      2:       return (x >= 10 && x <= 20 && y >= 5 && y <= 9);
      3:       return (y == 0 && x < 19) || (x == 63 && y == 47);
      default: return 1'b0;
    endcase
  endfunction

  // Drives one frame; the bench's own min/max/count model builds the expected result.
  task automatic drive_frame(input int w, input int h, input int mode, input bit fall_last,
                             input int low_cyc, input bit push);
    exp_t e;
    int n = 0, xmn = 1 << 30, xmx = -1, ymn = 1 << 30, ymx = -1;
    cur_row = -1;
    step(); vs = 1'b1; hs = 1'b0; ce = 1'b0; bi = 1'b0;
    repeat (2) step();
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        step(); hs = 1'b1; ce = 1'b1; bi = is_edge(mode, x, y); cur_x = x; cur_y = y;
        if (x == 0) cur_row = y;
        if (bi) begin
          n++;
          if (x < xmn) xmn = x;
          if (x > xmx) xmx = x;
          if (y < ymn) ymn = y;
          if (y > ymx) ymx = y;
        end
        if (fall_last && x == w - 1 && y == h - 1) begin vs = 1'b0; fall_cyc = cyc; end
      end
      step(); hs = 1'b0; ce = 1'b0; bi = 1'b0;
      step();
    end
    if (!fall_last) begin vs = 1'b0; fall_cyc = cyc; end
    e.cnt   = n;
    e.found = (n >= 16);
    e.xmin  = (n == 0) ? 0 : xmn;
    e.xmax  = (n == 0) ? 0 : xmx;
    e.ymin  = (n == 0) ? 0 : ymn;
    e.ymax  = (n == 0) ? 0 : ymx;
    e.vcyc  = fall_cyc + 2;
    if (push) sb_q.push_back(e);
    repeat (low_cyc - 1) step();
  endtask

  task automatic test_reset();
    repeat (3) step();
    rst = 1'b0;
    step();
    n_tests++;
    if ({bv, bf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b%b want 00", bv, bf); end
    n_tests++;
    if ({bxmin, bxmax, bymin, bymax, bcnt, s_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_box got %0d,%0d,%0d,%0d cnt=%0d want all 0", bxmin, bxmax, bymin, bymax, bcnt);
    end
    n_tests++;
    if ({o_vs, o_hs, o_ce, o_bit} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_stream got %b%b%b%b want 0000", o_vs, o_hs, o_ce, o_bit);
    end
  endtask

  task automatic test_single();
    drive_frame(8, 6, 1, 1'b0, 8, 1'b1);
  endtask

  task automatic test_rect();
    drive_frame(64, 48, 2, 1'b0, 8, 1'b1);
  endtask

  task automatic test_overlay();
    int ox[5] = '{10, 20, 15, 10, 15};
    int oy[5] = '{5, 9, 5, 7, 7};
    bit ob[5] = '{1, 1, 1, 1, 0};
    chk_stream = 1; cap_en = 1;
    drive_frame(64, 48, 0, 1'b0, 8, 1'b1);
    chk_stream = 0; cap_en = 0;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (cap[oy[i]][ox[i]] !== ob[i]) begin
        n_fail++; $display("FAIL overlay_px (%0d,%0d) got %b want %b", ox[i], oy[i], cap[oy[i]][ox[i]], ob[i]);
      end
    end
  endtask

  task automatic test_zero_frame();
    cap_en = 1;
    drive_frame(64, 48, 0, 1'b0, 8, 1'b1);
    cap_en = 0;
    n_tests++;
    if (cap[5][10] !== 1'b0 || cap[7][20] !== 1'b0) begin
      n_fail++; $display("FAIL overlay_off got %b%b want 00", cap[5][10], cap[7][20]);
    end
  endtask

  task automatic test_last_pixel_sat();
    drive_frame(64, 48, 3, 1'b1, 8, 1'b1);
  endtask

  task automatic test_reset_midframe();
    fork
      drive_frame(64, 48, 2, 1'b0, 8, 1'b0);
      begin
        wait (cur_row == 20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if ({bv, bf, bxmin, bxmax, bymin, bymax, bcnt} !== '0) begin
          n_fail++; $display("FAIL midframe_rst_box got %b %b %0d,%0d,%0d,%0d cnt=%0d want all 0", bv, bf, bxmin, bxmax, bymin, bymax, bcnt);
        end
        n_tests++;
        if ({o_vs, o_hs, o_ce, o_bit} !== 4'b0000) begin
          n_fail++; $display("FAIL midframe_rst_stream got %b%b%b%b want 0000", o_vs, o_hs, o_ce, o_bit);
        end
      end
    join
    drive_frame(64, 48, 2, 1'b0, 8, 1'b1);
  endtask

  task automatic test_back_to_back();
    drive_frame(64, 48, 2, 1'b0, 1, 1'b1);
    cap_en = 1;
    drive_frame(64, 48, 1, 1'b0, 8, 1'b1);
    cap_en = 0;
    n_tests++;
    if ({cap[7][20], cap[2][3], cap[7][30]} !== 3'b110) begin
      n_fail++; $display("FAIL b2b_overlay got %b%b%b want 110", cap[7][20], cap[2][3], cap[7][30]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_rect();
    test_overlay();
    test_zero_frame();
    test_last_pixel_sat();
    test_reset_midframe();
    test_back_to_back();
    repeat (20) step();
    n_tests++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_drain got %0d pending want 0", sb_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
